// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU memory request at a time, screens it for
// faults, drives the memory block for legal accesses and returns one response.
module load_store_unit #(
  parameter int ADDR_WIDTH = 13,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  input  logic [1:0]           req_size,
  input  logic                 req_sign,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_error,
  output logic [1:0]           resp_cause,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_data,
  output logic [1:0]           mem_size,
  output logic                 mem_sign,
  input  logic [BUS_WIDTH-1:0] mem_out,
  input  logic                 mem_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  state_t                 state_reg, state_next;
  logic                   we_reg, we_next;
  logic [BUS_WIDTH-1:0]   addr_reg, addr_next;
  logic [BUS_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [1:0]             size_reg, size_next;
  logic                   sign_reg, sign_next;
  logic [1:0]             cause_reg, cause_next;
  logic [BUS_WIDTH-1:0]   rdata_reg, rdata_next;

  logic                   accept;
  logic                   mem_active;
  logic [1:0]             req_cause;
  logic [BUS_WIDTH-1:0]   high_bits;

  // Address bits at or above ADDR_WIDTH mark a byte address beyond the memory.
  genvar gi;
  generate
    for (gi = 0; gi < BUS_WIDTH; gi = gi + 1) begin : g_high
      if (gi >= ADDR_WIDTH) begin : g_out
        assign high_bits[gi] = req_addr[gi];
      end else begin : g_in
        assign high_bits[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    req_cause = CAUSE_NONE;
    if (|high_bits) begin
      req_cause = CAUSE_RANGE;
    end else if (req_size == SIZE_BAD) begin
      req_cause = CAUSE_ILLEGAL;
    end else if (((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) ||
                 ((req_size == SIZE_HALF) && req_addr[0])) begin
      req_cause = CAUSE_MISALIGN;
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    size_next  = size_reg;
    sign_next  = sign_reg;
    cause_next = cause_reg;
    rdata_next = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          we_next    = req_we;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          size_next  = req_size;
          sign_next  = req_sign;
          cause_next = req_cause;
          rdata_next = '0;
          // Faulted requests never reach the memory.
          state_next = (req_cause != CAUSE_NONE) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          if (mem_error) begin
            cause_next = CAUSE_ILLEGAL;
          end
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A memory-reported fault returns zero data, like every other fault.
        rdata_next = mem_error ? '0 : mem_out;
        if (mem_error) begin
          cause_next = CAUSE_ILLEGAL;
        end
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      size_reg  <= 2'b00;
      sign_reg  <= 1'b0;
      cause_reg <= CAUSE_NONE;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      size_reg  <= size_next;
      sign_reg  <= sign_next;
      cause_reg <= cause_next;
      rdata_reg <= rdata_next;
    end
  end

  assign mem_active = (state_reg == ISSUE) || (state_reg == WAIT);
  assign mem_addr   = mem_active ? addr_reg  : '0;
  assign mem_data   = mem_active ? wdata_reg : '0;
  assign mem_size   = mem_active ? size_reg  : 2'b00;
  assign mem_sign   = mem_active ? sign_reg  : 1'b0;
  // Gated by rst_n so a store interrupted by reset never writes.
  assign mem_we     = (state_reg == ISSUE) && we_reg && rst_n;

  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_valid ? rdata_reg : '0;
  assign resp_cause = resp_valid ? cause_reg : CAUSE_NONE;
  assign resp_error = (resp_cause != CAUSE_NONE);

endmodule
